// File: rtl/delay_pkg.sv
// Shared types and constants for the delay-chain edge capture block.
package delay_pkg;

    localparam int DELAY_W    = 32;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/delay_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and same-cycle push+pop.
module delay_fifo
    import delay_pkg::*;
#(
    parameter int WIDTH = DELAY_W,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign valid_o = ~empty_o;
    assign level_o = cnt_q;

    // A pop frees the head slot this cycle, so a push into a full FIFO is still taken.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head is forced to zero when empty so the output never shows stale storage.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/delay_edge_capture.sv
// Synchronises the delay-chain tap, timestamps its rising edges with the free-running
// counter and queues the cycle count between consecutive edges for a valid/ready reader.
module delay_edge_capture
    import delay_pkg::*;
#(
    parameter int WIDTH = DELAY_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   path_in,
    input  logic [WIDTH-1:0]       count_in,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [1:0]             state_dbg
);

    logic             s1_q, s2_q, prev_q;
    logic             edge_det;
    cap_state_t       state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] delta;
    logic             push_req;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign edge_det  = s2_q & ~prev_q;
    // Modular subtraction: a counter wrap between edges still gives the true interval.
    assign delta     = count_in - last_q;
    assign pop       = out_valid & out_ready;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= path_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;
        case (state_q)
            IDLE: begin
                last_d = '0;
                if (en) begin
                    state_d    = ARM;
                    overflow_d = 1'b0;
                end
            end
            ARM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (edge_det) begin
                    last_d  = count_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (edge_det) begin
                    push_req = 1'b1;
                    last_d   = count_in;
                    // A dropped interval still advances the timestamp reference.
                    if (fifo_full && !pop) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    delay_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req),
        .push_data_i (delta),
        .pop_i       (pop),
        .rd_data_o   (out_data),
        .valid_o     (out_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    // out_valid already carries the non-empty flag; fifo_empty is kept for checker binding.
    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_delay_edge_capture.sv
// Self-checking bench: table-driven interval vectors, directed corner sequences and a
// randomized run scored against a queue-based interval model.
module tb_delay_edge_capture;
    import delay_pkg::*;

    localparam int W  = DELAY_W;
    localparam int D  = FIFO_DEPTH;
    localparam int LW = $clog2(D) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst, en, path_in, out_ready, out_valid, overflow;
    logic [W-1:0]  count_in, out_data;
    logic [LW-1:0] level;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    delay_edge_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .path_in   (path_in),
        .count_in  (count_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // ---------------- driver state ----------------
    logic         drv_rst, drv_en, drv_ready, rand_ready;
    logic [W-1:0] cnt;
    logic         prev_p;
    logic         pipe_r [2];
    logic [W-1:0] pipe_v [2];

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         m_on, m_has_last, m_ovf;
    logic [W-1:0] m_last;
    logic         checks_on;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // An edge seen while measuring: first one sets the reference, later ones yield intervals.
    task automatic model_edge(input logic [W-1:0] v);
        logic [W-1:0] d;
        if (!m_has_last) begin
            m_has_last = 1'b1;
            m_last     = v;
        end else begin
            d      = v - m_last;
            m_last = v;
            if (exp_q.size() < D) exp_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    // One clock: apply inputs on the falling edge, check state left by the last rising edge,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input logic p);
        logic         rise;
        logic [W-1:0] rv;
        @(negedge clk);
        if (rand_ready) drv_ready = ($urandom_range(0, 3) != 0);
        rst       = drv_rst;
        en        = drv_en;
        out_ready = drv_ready;
        path_in   = p;
        count_in  = cnt;
        rise      = p & ~prev_p;
        rv        = cnt;
        prev_p    = p;
        cnt       = cnt + 1;
        #1;
        if (checks_on) begin
            chk("level", level, exp_q.size());
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("overflow", overflow, m_ovf);
        end
        if (rst) begin
            exp_q.delete();
            m_on = 0; m_has_last = 0; m_ovf = 0; m_last = '0;
            pipe_r[0] = 0; pipe_r[1] = 0;
        end else begin
            if (out_ready && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0]);
                got_q.push_back(out_data);
                void'(exp_q.pop_front());
            end
            if (pipe_r[1] && m_on && en) model_edge(pipe_v[1]);
            pipe_r[1] = pipe_r[0]; pipe_v[1] = pipe_v[0];
            pipe_r[0] = rise;      pipe_v[0] = rv;
            if (!en) begin
                m_on = 0; m_has_last = 0;
            end else if (!m_on) begin
                m_on = 1; m_has_last = 0; m_ovf = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic pulse(input int high, input int low);
        repeat (high) step(1'b1);
        repeat (low) step(1'b0);
    endtask

    task automatic pulse_at(input logic [W-1:0] v, input int high, input int low);
        cnt = v;
        pulse(high, low);
    endtask

    task automatic do_reset();
        drv_rst = 1'b1;
        step(1'b0);
        drv_rst = 1'b0;
        step(1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] exp_d;
        bit           has_d;
    } vec_t;
    vec_t tab[5];

    logic [W-1:0] t_a, t_b;
    int           n_exp;

    initial begin
        tab[0] = '{cnt: 32'd100,        exp_d: 32'd0,          has_d: 1'b0};
        tab[1] = '{cnt: 32'd150,        exp_d: 32'd50,         has_d: 1'b1};
        tab[2] = '{cnt: 32'd230,        exp_d: 32'd80,         has_d: 1'b1};
        tab[3] = '{cnt: 32'hFFFF_FFF0,  exp_d: 32'hFFFF_FF0A,  has_d: 1'b1};
        tab[4] = '{cnt: 32'h0000_0010,  exp_d: 32'h0000_0020,  has_d: 1'b1};

        checks_on = 0; drv_rst = 1; drv_en = 0; drv_ready = 0; rand_ready = 0;
        cnt = '0; prev_p = 0; m_on = 0; m_has_last = 0; m_ovf = 0; m_last = '0;
        pipe_r[0] = 0; pipe_r[1] = 0; pipe_v[0] = '0; pipe_v[1] = '0;
        rst = 1; en = 0; path_in = 0; out_ready = 0; count_in = '0;
        repeat (2) @(posedge clk);
        step(1'b0);
        checks_on = 1;
        drv_rst   = 0;
        step(1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_state", state_dbg, IDLE);

        // Basic intervals and counter wrap, table driven.
        drv_en = 1; idle(2);
        got_q.delete();
        n_exp = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_at(tab[i].cnt, 2, 5);
            if (tab[i].has_d) n_exp++;
        end
        idle(4);
        chk("tab_level", level, n_exp);
        drv_ready = 1; idle(8); drv_ready = 0;
        chk("tab_count", got_q.size(), n_exp);
        n_exp = 0;
        for (int i = 0; i < 5; i++) begin
            if (tab[i].has_d) begin
                if (n_exp < got_q.size()) chk("tab_delta", got_q[n_exp], tab[i].exp_d);
                n_exp++;
            end
        end
        chk("tab_drained", level, 0);

        // Overflow: nine intervals into eight slots, then one after the dropped edge.
        do_reset(); idle(2);
        got_q.delete();
        pulse(2, 4);
        t_a = '0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) t_a = cnt;
            pulse(2, 4 + i);
        end
        idle(3);
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        drv_ready = 1; idle(10); drv_ready = 0;
        t_b = cnt;
        pulse(2, 4);
        idle(3);
        drv_ready = 1; idle(3); drv_ready = 0;
        chk("ovf_count", got_q.size(), 9);
        for (int k = 1; k <= 8; k++) begin
            if (k - 1 < got_q.size()) chk("ovf_order", got_q[k-1], (k == 1) ? 6 : k + 4);
        end
        if (got_q.size() > 8) chk("ovf_next", got_q[8], t_b - t_a);

        // Full FIFO: pop and push land on the same clock.
        do_reset(); idle(2);
        pulse(2, 4);
        repeat (8) pulse(2, 4);
        idle(3);
        chk("full_level", level, 8);
        step(1'b1); step(1'b1);
        drv_ready = 1; step(1'b0);
        drv_ready = 0; step(1'b0);
        chk("full_pp_level", level, 8);
        chk("full_pp_ovf", overflow, 0);
        drv_ready = 1; idle(12); drv_ready = 0;

        // Reset in the middle of a run.
        do_reset(); idle(2);
        pulse(2, 4); repeat (3) pulse(2, 4);
        idle(3);
        chk("mid_level", level, 3);
        do_reset();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_state", state_dbg, IDLE);
        pulse(2, 4); idle(3);
        chk("mid_rearm", level, 0);
        pulse(2, 4); idle(3);
        chk("mid_first", level, 1);
        drv_ready = 1; idle(4); drv_ready = 0;

        // Enable dropped with two queued; re-enable arms without pushing.
        do_reset(); idle(2);
        got_q.delete();
        pulse(2, 4); pulse(2, 4); pulse(2, 4);
        idle(3);
        drv_en = 0; idle(3);
        chk("en_off_level", level, 2);
        chk("en_off_state", state_dbg, IDLE);
        drv_ready = 1; idle(4); drv_ready = 0;
        chk("en_off_count", got_q.size(), 2);
        if (got_q.size() > 1) begin
            chk("en_off_d0", got_q[0], 6);
            chk("en_off_d1", got_q[1], 6);
        end
        drv_en = 1; idle(2);
        pulse(2, 4); idle(3);
        chk("reen_arm", level, 0);
        pulse(2, 4); idle(3);
        chk("reen_push", level, 1);
        drv_ready = 1; idle(4); drv_ready = 0;

        // Randomized pulses, counter jumps and reader back-pressure.
        do_reset(); idle(2);
        rand_ready = 1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) cnt = $urandom;
            pulse($urandom_range(1, 3), $urandom_range(2, 8));
        end
        rand_ready = 0;
        drv_ready  = 1; idle(20);
        chk("rand_drained", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
